elastic_buffer: RTL and testbench

Parameterised FIFO elastic buffer placed on each output branch of a CGRA processing element's fork stage. It supplies that branch's per-output ready bit to the fork sender, which ANDs the masked bits into its upstream ready. It decouples the sender from downstream stalls with `DEPTH` slots of storage. Its `io_ready_in` is derived only from registered occupancy, so no combinational ready path runs through the block, and chained fork/buffer stages do not form long ready chains.

---
 rtl/elastic_buffer_if.sv | 27 ++
 rtl/elastic_buffer.sv | 93 +++++++++
 tb/tb_elastic_buffer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/elastic_buffer_if.sv
// Handshake bundle between an upstream fork sender, one elastic_buffer and its consumer.
// Ports: io_din/io_valid_in/io_ready_in (upstream side), io_dout/io_valid_out/io_ready_out
//        (downstream side), io_count (occupancy). slave = buffer view, master = environment view.
interface elastic_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] io_din;
  logic             io_valid_in;
  logic             io_ready_in;
  logic [WIDTH-1:0] io_dout;
  logic             io_valid_out;
  logic             io_ready_out;
  logic [CW-1:0]    io_count;

  modport slave (
    input  io_din, io_valid_in, io_ready_out,
    output io_ready_in, io_dout, io_valid_out, io_count
  );

  modport master (
    output io_din, io_valid_in, io_ready_out,
    input  io_ready_in, io_dout, io_valid_out, io_count
  );
endinterface

// File: rtl/elastic_buffer.sv
// Purpose: DEPTH-slot circular FIFO on one fork output branch; io_ready_in comes from registered occupancy only.
// Latency: 1 cycle push-to-output; 0 cycles when ELASTIC_BUFFER_BYPASS_EN is defined and the buffer is empty.
// Backpressure: io_ready_in = (count != DEPTH); a pop while full does not free a slot for that same cycle.
// Ports: clock, reset (async, active low), bus (elastic_buffer_if.slave: io_din, io_valid_in, io_ready_in,
//        io_dout, io_valid_out, io_ready_out, io_count).
// Optional feature macro: ELASTIC_BUFFER_BYPASS_EN (empty-buffer pass-through).
module elastic_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic              clock,
  input logic              reset,
  elastic_buffer_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_empty;
  logic             w_ready_in;
  logic             w_valid_out;
  logic [WIDTH-1:0] w_dout;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;

  assign w_empty    = (r_count == '0);
  assign w_ready_in = (r_count != FULL_CNT);

`ifdef ELASTIC_BUFFER_BYPASS_EN
  // Pass-through only while empty and out of reset, so outputs stay 0 during reset.
  logic w_pass;
  assign w_pass = w_empty & reset;
  // Word handed straight to the consumer: neither stored nor popped.
  assign w_bypass = w_pass & bus.io_valid_in & bus.io_ready_out;

  always_comb begin
    w_valid_out = 1'b0;
    w_dout      = '0;
    if (w_pass) begin
      w_valid_out = bus.io_valid_in;
      w_dout      = bus.io_valid_in ? bus.io_din : '0;
    end else if (!w_empty) begin
      w_valid_out = 1'b1;
      w_dout      = r_mem[r_rd_ptr];
    end
  end
`else
  assign w_bypass    = 1'b0;
  assign w_valid_out = !w_empty;
  assign w_dout      = w_valid_out ? r_mem[r_rd_ptr] : '0;
`endif

  assign w_push = bus.io_valid_in & w_ready_in & !w_bypass;
  assign w_pop  = w_valid_out & bus.io_ready_out & !w_bypass;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.io_din;
  end

  assign bus.io_ready_in  = w_ready_in;
  assign bus.io_valid_out = w_valid_out;
  assign bus.io_dout      = w_dout;
  assign bus.io_count     = r_count;
endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer: DEPTH=2 instance (bus_a) and DEPTH=3 instance (bus_b) on a shared clock/reset.
module tb_elastic_buffer;
`ifdef ELASTIC_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock;
  logic reset;
  int   total;
  int   bad;

  elastic_buffer_if #(.WIDTH(32), .DEPTH(2)) bus_a ();
  elastic_buffer_if #(.WIDTH(32), .DEPTH(3)) bus_b ();

  elastic_buffer #(.WIDTH(32), .DEPTH(2)) u_a (.clock(clock), .reset(reset), .bus(bus_a.slave));
  elastic_buffer #(.WIDTH(32), .DEPTH(3)) u_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    // used only for display formatting of a comparison already decided by the caller
    $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_a.io_valid_in = 1'b1; bus_a.io_din = 32'hA5; bus_a.io_ready_out = 1'b0;
    bus_b.io_valid_in = 1'b0; bus_b.io_din = '0;     bus_b.io_ready_out = 1'b0;
    tick(); tick(); #1;
    total++; if (bus_a.io_valid_out !== 1'b0) begin bad++; chk("rst_valid_out", 32'(bus_a.io_valid_out), 0); end
    total++; if (bus_a.io_dout !== 32'h0) begin bad++; chk("rst_dout", bus_a.io_dout, 0); end
    total++; if (bus_a.io_count !== 2'd0) begin bad++; chk("rst_count", 32'(bus_a.io_count), 0); end
    total++; if (bus_a.io_ready_in !== 1'b1) begin bad++; chk("rst_ready_in", 32'(bus_a.io_ready_in), 1); end
    @(posedge clock); #1;
    reset = 1'b1; bus_a.io_valid_in = 1'b0;
    tick(); #1;
    total++; if (bus_a.io_count !== 2'd0) begin bad++; chk("rst_nothing_stored", 32'(bus_a.io_count), 0); end
    total++; if (bus_a.io_valid_out !== 1'b0) begin bad++; chk("rst_after_valid", 32'(bus_a.io_valid_out), 0); end
  endtask

  task automatic test_fill();
    bus_a.io_ready_out = 1'b0;
    bus_a.io_valid_in = 1'b1; bus_a.io_din = 32'h11; tick();
    bus_a.io_din = 32'h22; tick();
    bus_a.io_din = 32'h33; #1;
    total++; if (bus_a.io_count !== 2'd2) begin bad++; chk("fill_count", 32'(bus_a.io_count), 2); end
    total++; if (bus_a.io_ready_in !== 1'b0) begin bad++; chk("fill_ready_in", 32'(bus_a.io_ready_in), 0); end
    tick();
    total++; if (bus_a.io_count !== 2'd2) begin bad++; chk("fill_33_rejected", 32'(bus_a.io_count), 2); end
    bus_a.io_valid_in = 1'b0; bus_a.io_ready_out = 1'b1; #1;
    total++; if (bus_a.io_dout !== 32'h11 || bus_a.io_valid_out !== 1'b1) begin bad++; chk("fill_out0", bus_a.io_dout, 32'h11); end
    tick();
    total++; if (bus_a.io_dout !== 32'h22 || bus_a.io_valid_out !== 1'b1) begin bad++; chk("fill_out1", bus_a.io_dout, 32'h22); end
    tick();
    total++; if (bus_a.io_valid_out !== 1'b0 || bus_a.io_count !== 2'd0) begin bad++; chk("fill_drained", 32'(bus_a.io_count), 0); end
    bus_a.io_ready_out = 1'b0;
  endtask

  task automatic test_stream();
    bus_b.io_ready_out = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_b.io_valid_in = 1'b1; bus_b.io_din = 32'(i); #1;
      if (BYP) begin
        total++; if (bus_b.io_valid_out !== 1'b1 || bus_b.io_dout !== 32'(i)) begin bad++; chk("stream_byp_out", bus_b.io_dout, 32'(i)); end
      end else if (i > 0) begin
        total++; if (bus_b.io_valid_out !== 1'b1 || bus_b.io_dout !== 32'(i - 1)) begin bad++; chk("stream_out", bus_b.io_dout, 32'(i - 1)); end
      end
      total++; if (bus_b.io_count > 2'd1) begin bad++; chk("stream_count_le1", 32'(bus_b.io_count), 1); end
      tick();
    end
    bus_b.io_valid_in = 1'b0; #1;
    if (!BYP) begin
      total++; if (bus_b.io_valid_out !== 1'b1 || bus_b.io_dout !== 32'd9) begin bad++; chk("stream_last", bus_b.io_dout, 9); end
    end
    tick();
    total++; if (bus_b.io_count !== 2'd0 || bus_b.io_valid_out !== 1'b0) begin bad++; chk("stream_empty", 32'(bus_b.io_count), 0); end
    bus_b.io_ready_out = 1'b0;
  endtask

  task automatic test_full_pop();
    bus_a.io_ready_out = 1'b0;
    bus_a.io_valid_in = 1'b1; bus_a.io_din = 32'h41; tick();
    bus_a.io_din = 32'h42; tick();
    bus_a.io_din = 32'h43; bus_a.io_ready_out = 1'b1; #1;
    total++; if (bus_a.io_ready_in !== 1'b0) begin bad++; chk("fullpop_ready_in", 32'(bus_a.io_ready_in), 0); end
    tick();
    total++; if (bus_a.io_count !== 2'd1) begin bad++; chk("fullpop_count", 32'(bus_a.io_count), 1); end
    total++; if (bus_a.io_dout !== 32'h42) begin bad++; chk("fullpop_head", bus_a.io_dout, 32'h42); end
    bus_a.io_ready_out = 1'b0; #1;
    total++; if (bus_a.io_ready_in !== 1'b1) begin bad++; chk("fullpop_ready_again", 32'(bus_a.io_ready_in), 1); end
    tick();
    bus_a.io_valid_in = 1'b0;
    total++; if (bus_a.io_count !== 2'd2) begin bad++; chk("fullpop_push_next", 32'(bus_a.io_count), 2); end
    bus_a.io_ready_out = 1'b1; #1;
    total++; if (bus_a.io_dout !== 32'h42) begin bad++; chk("fullpop_drain0", bus_a.io_dout, 32'h42); end
    tick();
    total++; if (bus_a.io_dout !== 32'h43) begin bad++; chk("fullpop_drain1", bus_a.io_dout, 32'h43); end
    tick();
    total++; if (bus_a.io_count !== 2'd0) begin bad++; chk("fullpop_empty", 32'(bus_a.io_count), 0); end
    bus_a.io_ready_out = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus_a.io_ready_out = 1'b0;
    bus_a.io_valid_in = 1'b1; bus_a.io_din = 32'h51; tick();
    bus_a.io_din = 32'h52; tick();
    bus_a.io_valid_in = 1'b0;
    total++; if (bus_a.io_count !== 2'd2) begin bad++; chk("midrst_pre_count", 32'(bus_a.io_count), 2); end
    reset = 1'b0; #1;
    total++; if (bus_a.io_valid_out !== 1'b0) begin bad++; chk("midrst_valid_async", 32'(bus_a.io_valid_out), 0); end
    total++; if (bus_a.io_count !== 2'd0) begin bad++; chk("midrst_count_async", 32'(bus_a.io_count), 0); end
    tick();
    reset = 1'b1;
    bus_a.io_valid_in = 1'b1; bus_a.io_din = 32'h7E; tick();
    bus_a.io_valid_in = 1'b0; #1;
    total++; if (bus_a.io_valid_out !== 1'b1 || bus_a.io_dout !== 32'h7E) begin bad++; chk("midrst_first_out", bus_a.io_dout, 32'h7E); end
    bus_a.io_ready_out = 1'b1; tick();
    total++; if (bus_a.io_count !== 2'd0) begin bad++; chk("midrst_drained", 32'(bus_a.io_count), 0); end
    bus_a.io_ready_out = 1'b0;
  endtask

  // Reference: a queue of accepted words, front = head of buffer.
  task automatic test_random();
    logic [31:0] q[$];
    logic        e_ready, e_valid, ri0, hand;
    logic [31:0] e_dout;
    int          rx, tx;
    rx = 0; tx = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bus_a.io_valid_in  = 1'($urandom_range(0, 1));
      bus_a.io_din       = $urandom;
      bus_a.io_ready_out = 1'($urandom_range(0, 1));
      #1;
      ri0 = bus_a.io_ready_in;
      bus_a.io_ready_out = !bus_a.io_ready_out; #1;
      total++; if (bus_a.io_ready_in !== ri0) begin bad++; chk("rnd_ready_indep", 32'(bus_a.io_ready_in), 32'(ri0)); end
      bus_a.io_ready_out = !bus_a.io_ready_out; #1;

      e_ready = (q.size() != 2);
      e_valid = (q.size() != 0) || (BYP && bus_a.io_valid_in);
      e_dout  = (q.size() != 0) ? q[0] : ((BYP && bus_a.io_valid_in) ? bus_a.io_din : 32'h0);
      total++; if (bus_a.io_ready_in !== e_ready) begin bad++; chk("rnd_ready_in", 32'(bus_a.io_ready_in), 32'(e_ready)); end
      total++; if (bus_a.io_valid_out !== e_valid) begin bad++; chk("rnd_valid_out", 32'(bus_a.io_valid_out), 32'(e_valid)); end
      total++; if (bus_a.io_dout !== e_dout) begin bad++; chk("rnd_dout", bus_a.io_dout, e_dout); end
      total++; if (32'(bus_a.io_count) !== 32'(q.size())) begin bad++; chk("rnd_count", 32'(bus_a.io_count), 32'(q.size())); end

      hand = BYP && (q.size() == 0) && bus_a.io_valid_in && bus_a.io_ready_out;
      if (hand) begin
        rx++; tx++;
      end else begin
        if (e_valid && bus_a.io_ready_out) begin void'(q.pop_front()); rx++; end
        if (bus_a.io_valid_in && e_ready) begin q.push_back(bus_a.io_din); tx++; end
      end
      tick();
    end
    bus_a.io_valid_in = 1'b0;
    bus_a.io_ready_out = 1'b1;
    while (q.size() != 0) begin
      #1;
      total++; if (bus_a.io_dout !== q[0]) begin bad++; chk("rnd_drain", bus_a.io_dout, q[0]); end
      void'(q.pop_front()); rx++;
      tick();
    end
    total++; if (rx != tx) begin bad++; chk("rnd_no_loss", 32'(rx), 32'(tx)); end
    bus_a.io_ready_out = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_stream();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
